// File: rtl/z80_alu_pkg.sv
// Shared constants for the byte ALU and the sequential 16-bit wrapper.
// The ALU16_CARRY_IN_EN macro adds the LO_C carry-in state.
package z80_alu_pkg;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_XOR = 5'd4;
  localparam logic [4:0] ALU_NOP = 5'd31;

  typedef enum logic [2:0] {
    OP_ADD16 = 3'd0,
    OP_SUB16 = 3'd1,
    OP_AND16 = 3'd2,
    OP_OR16  = 3'd3,
    OP_XOR16 = 3'd4
  } op16_e;

`ifdef ALU16_CARRY_IN_EN
  typedef enum logic [2:0] {S_IDLE, S_LO, S_LO_C, S_HI, S_HI_C, S_DONE} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_HI_C, S_DONE} state_e;
`endif

  // Reserved 16-bit ops map to an alu_8 code that yields zero.
  function automatic logic [4:0] alu_opc(input logic [2:0] o);
    case (o)
      OP_ADD16: alu_opc = ALU_ADD;
      OP_SUB16: alu_opc = ALU_SUB;
      OP_AND16: alu_opc = ALU_AND;
      OP_OR16:  alu_opc = ALU_OR;
      OP_XOR16: alu_opc = ALU_XOR;
      default:  alu_opc = ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/alu_8.sv
// Combinational 8-bit ALU; unknown opcodes produce zero.
module alu_8
  import z80_alu_pkg::*;
(
  input  logic [4:0] opc,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  always_comb begin
    y = '0;
    case (opc)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_16_seq.sv
// Sequential 16-bit ALU built from one shared alu_8, low byte then high byte.
// Define ALU16_CARRY_IN_EN to add the cin port and the LO_C carry-in pass.
module alu_16_seq
  import z80_alu_pkg::*;
#(
  parameter int SKIP_FIX = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
`ifdef ALU16_CARRY_IN_EN
  input  logic        cin,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        carry,
  output logic        zero
);

  localparam bit ALWAYS_FIX = (SKIP_FIX == 0);

  state_e      state;
  logic [15:0] a_r, b_r;
  logic [2:0]  op_r;
  logic [7:0]  lo, hi;
  logic        c_lo, c_hi;
`ifdef ALU16_CARRY_IN_EN
  logic        cin_r;
`endif

  logic [7:0]  xa, xb, y;
  logic [4:0]  opc;
  logic        is_add, is_sub, is_arith;
  logic        byte_c, fix_c;

  assign is_add   = (op_r == OP_ADD16);
  assign is_sub   = (op_r == OP_SUB16);
  assign is_arith = is_add | is_sub;
  assign opc      = alu_opc(op_r);

  always_comb begin
    xa = '0;
    xb = '0;
    case (state)
      S_LO:   begin xa = a_r[7:0];  xb = b_r[7:0];      end
`ifdef ALU16_CARRY_IN_EN
      S_LO_C: begin xa = lo;        xb = {7'b0, cin_r}; end
`endif
      S_HI:   begin xa = a_r[15:8]; xb = b_r[15:8];     end
      S_HI_C: begin xa = hi;        xb = {7'b0, c_lo};  end
      default: ;
    endcase
  end

  alu_8 u_alu (
    .opc (opc),
    .a   (xa),
    .b   (xb),
    .y   (y)
  );

  // Fix passes carry the pending bit in xb[0]: add wraps to 00, sub borrows from 00.
  assign byte_c = is_add ? (y < xa) : (is_sub ? (xa < xb) : 1'b0);
  assign fix_c  = xb[0] & (is_add ? (y == 8'h00) : (xa == 8'h00));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= '0;
      lo        <= '0;
      hi        <= '0;
      c_lo      <= 1'b0;
      c_hi      <= 1'b0;
`ifdef ALU16_CARRY_IN_EN
      cin_r     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            a_r      <= a;
            b_r      <= b;
            op_r     <= op;
`ifdef ALU16_CARRY_IN_EN
            cin_r    <= cin;
`endif
            in_ready <= 1'b0;
            state    <= S_LO;
          end
        end
        S_LO: begin
          lo    <= y;
          c_lo  <= byte_c;
          state <= S_HI;
`ifdef ALU16_CARRY_IN_EN
          if (is_arith && (cin_r || ALWAYS_FIX)) state <= S_LO_C;
`endif
        end
`ifdef ALU16_CARRY_IN_EN
        S_LO_C: begin
          lo    <= y;
          c_lo  <= c_lo | fix_c;
          state <= S_HI;
        end
`endif
        S_HI: begin
          hi   <= y;
          c_hi <= byte_c;
          if (is_arith && (c_lo || ALWAYS_FIX)) begin
            state <= S_HI_C;
          end else begin
            result    <= {y, lo};
            carry     <= byte_c;
            zero      <= ({y, lo} == 16'h0000);
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_HI_C: begin
          hi        <= y;
          result    <= {y, lo};
          carry     <= c_hi | fix_c;
          zero      <= ({y, lo} == 16'h0000);
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_16_seq.sv
// Bench for alu_16_seq: one SKIP_FIX=1 and one SKIP_FIX=0 instance driven with directed vectors.
module tb_alu_16_seq;

`ifdef ALU16_CARRY_IN_EN
  localparam bit CIN_EN = 1'b1;
`else
  localparam bit CIN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        iv [2];
  logic        ir [2];
  logic        ov [2];
  logic        ordy [2];
  logic        cy [2];
  logic        zr [2];
  logic        ci [2];
  logic [2:0]  opv [2];
  logic [15:0] av [2];
  logic [15:0] bv [2];
  logic [15:0] res [2];

  logic        armed [2];
  logic [15:0] mres [2];
  logic        mcar [2];
  logic        mzero [2];

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_16_seq #(.SKIP_FIX(1)) dut_skip (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .op(opv[0]),
    .a(av[0]), .b(bv[0]),
`ifdef ALU16_CARRY_IN_EN
    .cin(ci[0]),
`endif
    .out_valid(ov[0]), .out_ready(ordy[0]), .result(res[0]), .carry(cy[0]), .zero(zr[0])
  );

  alu_16_seq #(.SKIP_FIX(0)) dut_fixed (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .op(opv[1]),
    .a(av[1]), .b(bv[1]),
`ifdef ALU16_CARRY_IN_EN
    .cin(ci[1]),
`endif
    .out_valid(ov[1]), .out_ready(ordy[1]), .result(res[1]), .carry(cy[1]), .zero(zr[1])
  );

  task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passes++;
    else $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, got, exp, $time);
  endtask

  // Whole-word reference: {carry/borrow, result} from 17-bit arithmetic.
  function automatic logic [16:0] model(input logic [2:0] o, input logic [15:0] x,
                                        input logic [15:0] y, input logic c);
    case (o)
      3'd0:    model = {1'b0, x} + {1'b0, y} + 17'(c);
      3'd1:    model = {1'b0, x} - {1'b0, y} - 17'(c);
      3'd2:    model = {1'b0, x & y};
      3'd3:    model = {1'b0, x | y};
      3'd4:    model = {1'b0, x ^ y};
      default: model = '0;
    endcase
  endfunction

  function automatic int lat_model(input logic [2:0] o, input logic [15:0] x,
                                   input logic [15:0] y, input logic c, input bit skip);
    logic [8:0] l;
    lat_model = 2;
    if (o <= 3'd1) begin
      if (CIN_EN && (c || !skip)) lat_model++;
      l = (o == 3'd0) ? ({1'b0, x[7:0]} + {1'b0, y[7:0]} + 9'(c))
                      : ({1'b0, x[7:0]} - {1'b0, y[7:0]} - 9'(c));
      if (l[8] || !skip) lat_model++;
    end
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        if (ov[d]) begin
          if (!armed[d]) chk("unexpected_out_valid", d, 32'(ov[d]), 32'd0);
          else begin
            chk("result", d, 32'(res[d]), 32'(mres[d]));
            chk("carry", d, 32'(cy[d]), 32'(mcar[d]));
            chk("zero", d, 32'(zr[d]), 32'(mzero[d]));
            chk("in_ready_in_done", d, 32'(ir[d]), 32'd0);
          end
        end
      end
    end
  end

  task automatic run(input int d, input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                     input logic c, input logic [15:0] hres, input logic hcar, input int hlat,
                     input int hold);
    int n;
    int lat;
    logic [16:0] m;
    n = 0;
    while (!ir[d] && n < 20) begin @(posedge clk); #1; n++; end
    if (!ir[d]) chk("in_ready_wait", d, 32'(ir[d]), 32'd1);
    m        = model(o, x, y, c);
    mres[d]  = m[15:0];
    mcar[d]  = m[16];
    mzero[d] = (m[15:0] == 16'h0000);
    armed[d] = 1'b1;
    opv[d] = o; av[d] = x; bv[d] = y; ci[d] = c; iv[d] = 1'b1;
    @(posedge clk); #1;
    iv[d] = 1'b0; opv[d] = 3'd3; av[d] = ~x; bv[d] = ~y; ci[d] = ~c;
    lat = 0;
    while (!ov[d] && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("latency", d, 32'(lat), 32'(lat_model(o, x, y, c, d == 0)));
    chk("hand_latency", d, 32'(lat), 32'(hlat));
    chk("hand_result", d, 32'(res[d]), 32'(hres));
    chk("hand_carry", d, 32'(cy[d]), 32'(hcar));
    chk("hand_zero", d, 32'(zr[d]), 32'(hres == 16'h0000));
    repeat (hold) begin @(posedge clk); #1; end
    if (hold > 0) begin
      chk("out_valid_held", d, 32'(ov[d]), 32'd1);
      chk("in_ready_held", d, 32'(ir[d]), 32'd0);
    end
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d]  = 1'b0;
    armed[d] = 1'b0;
    chk("out_valid_after_pop", d, 32'(ov[d]), 32'd0);
    chk("in_ready_after_pop", d, 32'(ir[d]), 32'd1);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [15:0] r;
    logic        cy;
    int          l1;
    int          l0;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int hl;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b0; ci[d] = 1'b0; opv[d] = '0; av[d] = '0; bv[d] = '0;
      armed[d] = 1'b0; mres[d] = '0; mcar[d] = 1'b0; mzero[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", d, 32'(ir[d]), 32'd1);
      chk("rst_out_valid", d, 32'(ov[d]), 32'd0);
      chk("rst_result", d, 32'(res[d]), 32'd0);
      chk("rst_carry", d, 32'(cy[d]), 32'd0);
      chk("rst_zero", d, 32'(zr[d]), 32'd0);
    end

    vecs.push_back(vec_t'{3'd0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 2, 3});
    vecs.push_back(vec_t'{3'd0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 3, 3});
    vecs.push_back(vec_t'{3'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 3, 3});
    vecs.push_back(vec_t'{3'd1, 16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 3, 3});
    vecs.push_back(vec_t'{3'd1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 3, 3});
    vecs.push_back(vec_t'{3'd4, 16'hFFFF, 16'h8A8A, 1'b0, 16'h7575, 1'b0, 2, 2});
    vecs.push_back(vec_t'{3'd6, 16'h1234, 16'h5678, 1'b0, 16'h0000, 1'b0, 2, 2});
    vecs.push_back(vec_t'{3'd2, 16'hF0F0, 16'h3C3C, 1'b0, 16'h3030, 1'b0, 2, 2});
    vecs.push_back(vec_t'{3'd3, 16'h1200, 16'h0034, 1'b0, 16'h1234, 1'b0, 2, 2});
    vecs.push_back(vec_t'{3'd1, 16'h5678, 16'h1234, 1'b0, 16'h4444, 1'b0, 2, 3});
    vecs.push_back(vec_t'{3'd0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 2, 3});
`ifdef ALU16_CARRY_IN_EN
    vecs.push_back(vec_t'{3'd0, 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 4, 4});
    vecs.push_back(vec_t'{3'd1, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 4, 4});
`endif

    foreach (vecs[i]) begin
      for (int d = 0; d < 2; d++) begin
        // Carry-in vectors already list both fix passes; others gain LO_C only on the fixed-latency unit.
        hl = (d == 0) ? vecs[i].l1
                      : vecs[i].l0 + ((CIN_EN && !vecs[i].c && vecs[i].op <= 3'd1) ? 1 : 0);
        run(d, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].r, vecs[i].cy, hl,
            (i == 0) ? 5 : (i % 2));
      end
    end

    // Reset while dut_skip sits in HI abandons the operation.
    iv[0] = 1'b1; opv[0] = 3'd0; av[0] = 16'h00FF; bv[0] = 16'h0001; ci[0] = 1'b0;
    @(posedge clk); #1 iv[0] = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("rst_hi_out_valid", 0, 32'(ov[0]), 32'd0);
    chk("rst_hi_in_ready", 0, 32'(ir[0]), 32'd1);
    chk("rst_hi_result", 0, 32'(res[0]), 32'd0);
    repeat (4) @(posedge clk);
    #1 chk("rst_hi_no_result", 0, 32'(ov[0]), 32'd0);

    // Reset beats a simultaneous in_valid.
    iv[1] = 1'b1; opv[1] = 3'd0; av[1] = 16'h0001; bv[1] = 16'h0001; reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_prio_in_ready", 1, 32'(ir[1]), 32'd1);
    iv[1] = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_prio_idle", 1, 32'(ir[1]), 32'd1);

    run(1, 3'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, CIN_EN ? 4 : 3, 1);
    run(0, 3'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 3, 0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/alu_16_seq.md
ALU_16_SEQ -- requirements
Module: alu_16_seq

Interface
REQ-001 SHALL have parameter SKIP_FIX, default 1; 1 omits a carry-fix pass when no carry is pending, 0 always runs it for fixed latency.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have in_valid input 1 and in_ready output 1, the request handshake.
REQ-005 SHALL have op input 3: 0 ADD16, 1 SUB16, 2 AND16, 3 OR16, 4 XOR16; 5-7 reserved.
REQ-006 SHALL have a input 16 and b input 16, the operands.
REQ-007 SHALL have out_valid output 1 and out_ready input 1, the result handshake.
REQ-008 SHALL have result output 16, carry output 1 (carry or borrow) and zero output 1.
REQ-009 SHALL have cin input 1, carry or borrow in, present only under ALU16_CARRY_IN_EN.

Function
REQ-010 SHALL compute every byte result through one alu_8 instance: ALU opcode 0 add, 1 sub, 2 and, 3 or, 4 xor.
REQ-011 SHALL implement the FSM IDLE -> LO -> [LO_C] -> HI -> [HI_C] -> DONE -> IDLE, one cycle per state except DONE.
REQ-012 SHALL assert in_ready only in IDLE; a, b and op SHALL be latched on the edge where in_valid && in_ready.
REQ-013 LO SHALL register lo = a[7:0] op b[7:0]; for ADD c_lo = (lo < a[7:0]), for SUB c_lo = (a[7:0] < b[7:0]).
REQ-014 HI SHALL register hi = a[15:8] op b[15:8]; for ADD c_hi = (hi < a[15:8]), for SUB c_hi = (a[15:8] < b[15:8]).
REQ-015 HI_C SHALL run when c_lo = 1 or SKIP_FIX = 0, and SHALL feed alu_8 (hi, {7'b0, c_lo}) with the same add or sub.
REQ-016 HI_C carry: for ADD c_fix = c_lo && (new hi == 8'h00); for SUB c_fix = c_lo && (old hi == 8'h00).
REQ-017 Final carry SHALL be c_hi | c_fix for ADD and SUB, and 0 for AND, OR and XOR.
REQ-018 Logic ops SHALL never enter a fix state, regardless of SKIP_FIX.
REQ-019 Reserved ops SHALL run the normal path and give result 16'h0000, carry 0, zero 1.
REQ-020 zero SHALL equal (result == 16'h0000).
REQ-021 out_valid SHALL be high exactly in DONE; result, carry and zero SHALL stay stable while out_valid && !out_ready.
REQ-022 DONE -> IDLE SHALL occur on out_valid && out_ready; in_ready rises the following cycle, with no same-cycle turnaround.
REQ-023 Latency SHALL be 2 edges from the accepting edge to out_valid high, +1 per executed fix pass.

Reset
REQ-024 reset SHALL force IDLE, in_ready 1, out_valid 0, result 16'h0000, carry 0, zero 0.
REQ-025 reset during any state SHALL abandon the operation without emitting a result.
REQ-026 reset SHALL take priority over a simultaneous in_valid or out_ready.

Configuration
REQ-027 With ALU16_CARRY_IN_EN defined, the block SHALL include cin, latch it with the operands, and run LO_C on ADD/SUB when cin = 1 or SKIP_FIX = 0.
REQ-028 LO_C SHALL add or subtract cin from lo, and c_lo SHALL become c_lo | fix carry using the REQ-016 rules.
REQ-029 With ALU16_CARRY_IN_EN undefined, the block SHALL have no cin port, no LO_C state, and cin treated as 0.

Structure
REQ-030 Package z80_alu_pkg SHALL hold the alu_8 opcode constants (5-bit), the 3-bit op16 enum and the FSM state enum.
REQ-031 alu_8 SHALL be the only sub-module; the byte datapath and carry logic SHALL stay in alu_16_seq.

Verification
REQ-032 ADD16 1234 + 1111 -> 2345, carry 0, zero 0, latency 2; with SKIP_FIX = 0 the latency is 3.
REQ-033 ADD16 00FF + 0001 -> 0100, carry 0, latency 3; ADD16 FFFF + 0001 -> 0000, carry 1, zero 1.
REQ-034 SUB16 0100 - 0001 -> 00FF, carry 0, latency 3; SUB16 0000 - 0001 -> FFFF, carry 1.
REQ-035 XOR16 FFFF ^ 8A8A -> 7575, carry 0, latency 2; reserved op 6 -> 0000, zero 1.
REQ-036 Hold out_ready low 5 cycles -> outputs stable and in_ready 0 throughout; pulse reset in HI -> out_valid 0 and in_ready 1 after that edge.
REQ-037 With ALU16_CARRY_IN_EN, ADD16 00FF + 0000 with cin 1 -> 0100, carry 0, latency 4.
